xor_lfsr_scrambler: RTL and testbench
=====================================

// Module: xor_lfsr_scrambler
// PURPOSE
//  Parametrised XOR-network successor to the NAND-built XOR gate: multiplicative (self-synchronising) LFSR
//  scrambler/descrambler, WIDTH bits per clock, runtime-selectable mode.
//  Sits between a word-stream source and a serial/PHY-style sink; one instance per direction.
//  Valid/ready on both sides; one registered output stage.
// PARAMETERS
//  WIDTH    8           data bits processed per accepted word (1..64)
//  LFSR_LEN 7           LFSR state length in bits (2..32)
//  TAPS     7'b1100000  LFSR_LEN-bit mask; bit k set => S[k] feeds the XOR feedback (default x^7+x^6+1)
//  SEED     7'h7F       LFSR_LEN-bit state loaded at reset and on seed_load
// PORTS
//  clk        in   1         sole clock, rising edge
//  rst        in   1         synchronous, active-high reset
//  mode       in   1         0 = scramble, 1 = descramble; sampled on each accepted word
//  seed_load  in   1         1-cycle pulse: S <= SEED
//  in_valid   in   1         input word present
//  in_ready   out  1         block can accept input word
//  in_data    in   WIDTH     input word, bit 0 processed first
//  out_valid  out  1         output register holds a word
//  out_ready  in   1         sink accepts output word
//  out_data   out  WIDTH     scrambled/descrambled word
//  out_parity out  1         only with SCRAMBLER_PARITY_EN: XOR of out_data bits
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): S=SEED, out_valid=0, out_data=0, out_parity=0. Reset beats every other input.
//    A word held in the output register is discarded. Input offered in the reset cycle is not accepted.
//  - in_ready = !out_valid || out_ready (combinational; no skid buffer).
//  - Accept = in_valid && in_ready. Latency is 1 cycle: the word accepted at edge N appears on out_data after edge N.
//  - Per bit i = 0..WIDTH-1, applied in sequence within one cycle: fb = ^(S & TAPS); o[i] = in[i] ^ fb.
//    Scramble: S = {S[LEN-2:0], o[i]}. Descramble: S = {S[LEN-2:0], in[i]}.
//  - S advances only on accept. Backpressure (out_valid && !out_ready) freezes S, out_data and out_valid.
//  - Output register: loads on accept. Otherwise out_valid clears when out_ready=1. Otherwise it holds.
//  - seed_load without accept: S <= SEED, out register unaffected.
//  - seed_load with accept in the same cycle: that word is processed starting from SEED.
//  - mode change takes effect on the next accepted word; S is not reset by a mode change.
//  - S = 0 in scramble mode with all-zero input is the lock-up state; it is legal and is not corrected.
//  - Descrambler self-syncs: after LFSR_LEN correct input bits, output is correct regardless of initial S.
// CONFIGURATION
//  SCRAMBLER_PARITY_EN defined: out_parity port exists, registered with out_data (same load/hold/reset rules).
//  Not defined: port absent; no parity logic.
// STRUCTURE
//  scrambler_pkg: PRBS polynomial constants (PRBS7/PRBS15/PRBS23 TAPS + default SEED); mode enum
//    {MODE_SCRAMBLE=0, MODE_DESCRAMBLE=1}.
//  Sub-module scrambler_bit_step: combinational one-bit stage (S, in_bit, mode -> o_bit, S_next).
//    Generate-chained WIDTH times in the top; top holds S and the output register.
// TESTING
//  1 Reset then scramble 0x00 x4, seed_load with SEED overridden to 0 -> out_data 0x00 every word (lock-up).
//  2 Scrambler->descrambler loopback, same SEED, 256 random words, random out_ready -> descrambled == original,
//    no loss or duplication.
//  3 Descrambler SEED 7'h00 vs scrambler 7'h7F, WIDTH=8 -> first word may differ; words from the 2nd onward match.
//  4 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_data/S frozen. Release -> exactly one
//    word accepted per cycle.
//  5 Assert rst while out_valid=1 -> next cycle out_valid=0. Next word is scrambled from SEED, matching a fresh run.
//  6 seed_load coincident with accept, and (parity build) random words -> word processed from SEED;
//    out_parity == ^out_data.

Source files
------------

// File: rtl/xor_lfsr_scrambler_pkg.sv
// Shared constants for the multiplicative LFSR scrambler: PRBS tap masks, default seed, mode encoding.
// Optional SCRAMBLER_PARITY_EN (see top) adds a registered parity bit on the output stream.
package xor_lfsr_scrambler_pkg;

  localparam logic [6:0]  PRBS7_TAPS   = 7'b110_0000;   // x^7 + x^6 + 1
  localparam logic [14:0] PRBS15_TAPS  = 15'h6000;      // x^15 + x^14 + 1
  localparam logic [22:0] PRBS23_TAPS  = 23'h42_0000;   // x^23 + x^18 + 1
  localparam logic [6:0]  DEFAULT_SEED = 7'h7F;

  typedef enum logic {
    MODE_SCRAMBLE   = 1'b0,
    MODE_DESCRAMBLE = 1'b1
  } mode_e;

endpackage

// File: rtl/xor_lfsr_scrambler_if.sv
// Valid/ready word stream; parity rides along only when SCRAMBLER_PARITY_EN is defined.
interface xor_lfsr_scrambler_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
`ifdef SCRAMBLER_PARITY_EN
  logic             parity;
`endif

  modport master (
    output valid,
    output data,
`ifdef SCRAMBLER_PARITY_EN
    output parity,
`endif
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/xor_lfsr_scrambler_bit_step.sv
// One combinational LFSR bit stage; the top chains WIDTH of these per clock.
module xor_lfsr_scrambler_bit_step
  import xor_lfsr_scrambler_pkg::*;
#(
  parameter int                  LFSR_LEN = 7,
  parameter logic [LFSR_LEN-1:0] TAPS     = PRBS7_TAPS
) (
  input  logic [LFSR_LEN-1:0] s,
  input  logic                in_bit,
  input  mode_e               mode,
  output logic                o_bit,
  output logic [LFSR_LEN-1:0] s_next
);
  logic fb;

  assign fb    = ^(s & TAPS);
  assign o_bit = in_bit ^ fb;
  // Descrambler shifts in the line bit, which is what makes it self-synchronising.
  assign s_next = {s[LFSR_LEN-2:0], (mode == MODE_DESCRAMBLE) ? in_bit : o_bit};
endmodule

// File: rtl/xor_lfsr_scrambler.sv
// Multiplicative LFSR scrambler/descrambler, WIDTH bits per accepted word, one registered output stage.
// Define SCRAMBLER_PARITY_EN to add out_m.parity (XOR of the output word, registered with it).
module xor_lfsr_scrambler
  import xor_lfsr_scrambler_pkg::*;
#(
  parameter int                  WIDTH    = 8,
  parameter int                  LFSR_LEN = 7,
  parameter logic [LFSR_LEN-1:0] TAPS     = PRBS7_TAPS,
  parameter logic [LFSR_LEN-1:0] SEED     = DEFAULT_SEED
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic                   seed_load,
  xor_lfsr_scrambler_if.slave    in_s,
  xor_lfsr_scrambler_if.master   out_m
);
  logic [LFSR_LEN-1:0] s_q;
  logic [LFSR_LEN-1:0] s_chain [WIDTH+1];
  logic [WIDTH-1:0]    o_word;
  logic [WIDTH-1:0]    data_q;
  logic                valid_q;
  logic                in_rdy;
  logic                accept;

  assign in_rdy     = !valid_q || out_m.ready;
  assign in_s.ready = in_rdy;
  assign accept     = in_s.valid && in_rdy;

  // A coincident seed_load restarts this very word from SEED.
  assign s_chain[0] = seed_load ? SEED : s_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    xor_lfsr_scrambler_bit_step #(
      .LFSR_LEN (LFSR_LEN),
      .TAPS     (TAPS)
    ) u_step (
      .s      (s_chain[i]),
      .in_bit (in_s.data[i]),
      .mode   (mode_e'(mode)),
      .o_bit  (o_word[i]),
      .s_next (s_chain[i+1])
    );
  end

`ifdef SCRAMBLER_PARITY_EN
  logic parity_q;
  assign out_m.parity = parity_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= SEED;
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef SCRAMBLER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (accept) begin
      s_q     <= s_chain[WIDTH];
      valid_q <= 1'b1;
      data_q  <= o_word;
`ifdef SCRAMBLER_PARITY_EN
      parity_q <= ^o_word;
`endif
    end else begin
      if (seed_load)   s_q     <= SEED;
      if (out_m.ready) valid_q <= 1'b0;
    end
  end

  assign out_m.valid = valid_q;
  assign out_m.data  = data_q;
endmodule

// File: tb/tb_xor_lfsr_scrambler.sv
// Bench: directed + random checks of the LFSR scrambler against a bit-history reference model.
module tb_xor_lfsr_scrambler;
  typedef bit bq_t[$];

  localparam logic [6:0] SEED7 = 7'h7F;
  localparam logic [6:0] TAPS7 = 7'b110_0000;

  logic clk = 1'b0;
  logic rst;
  logic mode_m, seed_m, mode_a, seed_a;
  logic mode_ls, mode_ld, seed_l;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  xor_lfsr_scrambler_if #(.WIDTH(8)) m_in ();
  xor_lfsr_scrambler_if #(.WIDTH(8)) m_out ();
  xor_lfsr_scrambler_if #(.WIDTH(8)) a_in ();
  xor_lfsr_scrambler_if #(.WIDTH(8)) a_out ();
  xor_lfsr_scrambler_if #(.WIDTH(8)) l_in ();
  xor_lfsr_scrambler_if #(.WIDTH(8)) l_link ();
  xor_lfsr_scrambler_if #(.WIDTH(8)) l_out ();

  xor_lfsr_scrambler #(.WIDTH(8), .LFSR_LEN(7), .TAPS(TAPS7), .SEED(SEED7)) u_main (
    .clk(clk), .rst(rst), .mode(mode_m), .seed_load(seed_m), .in_s(m_in), .out_m(m_out));
  xor_lfsr_scrambler #(.WIDTH(8), .LFSR_LEN(7), .TAPS(TAPS7), .SEED(7'h00)) u_alt (
    .clk(clk), .rst(rst), .mode(mode_a), .seed_load(seed_a), .in_s(a_in), .out_m(a_out));
  xor_lfsr_scrambler #(.WIDTH(8), .LFSR_LEN(7), .TAPS(TAPS7), .SEED(SEED7)) u_lscr (
    .clk(clk), .rst(rst), .mode(mode_ls), .seed_load(seed_l), .in_s(l_in), .out_m(l_link));
  xor_lfsr_scrambler #(.WIDTH(8), .LFSR_LEN(7), .TAPS(TAPS7), .SEED(SEED7)) u_ldes (
    .clk(clk), .rst(rst), .mode(mode_ld), .seed_load(seed_l), .in_s(l_link), .out_m(l_out));

  // h[k] is the bit shifted in k+1 steps ago; h[0] the newest.
  function automatic bq_t hist_of(input logic [6:0] sd);
    bq_t q;
    for (int k = 0; k < 7; k++) q.push_back(bit'(sd[k]));
    return q;
  endfunction

  function automatic logic [7:0] mdl(input logic [7:0] din, input bit desc, inout bq_t h);
    logic [7:0] r;
    logic [6:0] tp;
    bit fb, o;
    tp = TAPS7;
    r  = '0;
    for (int i = 0; i < 8; i++) begin
      fb = 1'b0;
      for (int k = 0; k < 7; k++) if (tp[k]) fb = fb ^ h[k];
      o    = din[i] ^ fb;
      r[i] = o;
      h.push_front(desc ? bit'(din[i]) : o);
      void'(h.pop_back());
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bq_t hm, hs, hd, hl;
    logic [7:0] w, exp, orig;
    logic [7:0] src[$], sent[$], link_q[$], recv[$];
    int sidx, cyc;
    bit md;

    rst = 1'b1;
    mode_m = 1'b0; seed_m = 1'b0; mode_a = 1'b0; seed_a = 1'b0;
    mode_ls = 1'b0; mode_ld = 1'b1; seed_l = 1'b0;
    m_in.valid = 1'b0; m_in.data = '0; m_out.ready = 1'b0;
    a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
    l_in.valid = 1'b0; l_in.data = '0; l_out.ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // reset state
    check("rst_valid", m_out.valid, 0);
    check("rst_data", m_out.data, 0);
    check("rst_in_ready", m_in.ready, 1);
    check("rst_alt_valid", a_out.valid, 0);
`ifdef SCRAMBLER_PARITY_EN
    check("rst_parity", m_out.parity, 0);
`endif

    // lock-up: SEED=0, scramble all-zero words
    seed_a = 1'b1; tick(); seed_a = 1'b0;
    a_out.ready = 1'b1; a_in.valid = 1'b1; a_in.data = 8'h00;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("lock_valid", a_out.valid, 1);
      check("lock_data", a_out.data, 8'h00);
    end
    a_in.valid = 1'b0;

    // descrambler seeded 0 against a scrambler seeded 7F
    mode_a = 1'b1; seed_a = 1'b1; tick(); seed_a = 1'b0;
    hs = hist_of(SEED7); hd = hist_of(7'h00);
    for (int j = 0; j < 6; j++) begin
      orig = 8'($urandom);
      w = mdl(orig, 1'b0, hs);
      a_in.valid = 1'b1; a_in.data = w;
      tick();
      exp = mdl(w, 1'b1, hd);
      check("sync_model", a_out.data, exp);
      if (j >= 1) check("sync_orig", a_out.data, orig);
    end
    a_in.valid = 1'b0;

    // loopback with random valid/ready
    for (int j = 0; j < 256; j++) src.push_back(8'($urandom));
    sidx = 0; cyc = 0;
    while (recv.size() < 256 && cyc < 5000) begin
      l_in.valid  = (sidx < 256) && ($urandom_range(0, 3) != 0);
      l_in.data   = (sidx < 256) ? src[sidx] : 8'h00;
      l_out.ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (l_in.valid && l_in.ready) begin sent.push_back(l_in.data); sidx++; end
      if (l_link.valid && l_link.ready) link_q.push_back(l_link.data);
      if (l_out.valid && l_out.ready) recv.push_back(l_out.data);
      tick();
      cyc++;
    end
    l_in.valid = 1'b0; l_out.ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (l_out.valid && l_out.ready) recv.push_back(l_out.data);
      tick();
    end
    check("lb_sent", sent.size(), 256);
    check("lb_link_cnt", link_q.size(), 256);
    check("lb_recv_cnt", recv.size(), 256);
    hl = hist_of(SEED7);
    for (int j = 0; j < 256; j++) begin
      exp = mdl(src[j], 1'b0, hl);
      if (j < link_q.size()) check("lb_link", link_q[j], exp);
      if (j < recv.size())   check("lb_recv", recv[j], src[j]);
    end

    // backpressure freezes output and state
    hm = hist_of(SEED7);
    m_out.ready = 1'b1; m_in.valid = 1'b1;
    w = 8'($urandom); m_in.data = w;
    tick();
    exp = mdl(w, 1'b0, hm);
    check("bp_first", m_out.data, exp);
    m_out.ready = 1'b0;
    w = 8'($urandom); m_in.data = w;
    for (int j = 0; j < 5; j++) begin
      #1;
      check("bp_in_ready", m_in.ready, 0);
      tick();
      check("bp_valid", m_out.valid, 1);
      check("bp_data", m_out.data, exp);
    end
    m_out.ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      exp = mdl(w, 1'b0, hm);
      check("rel_valid", m_out.valid, 1);
      check("rel_data", m_out.data, exp);
      w = 8'($urandom); m_in.data = w;
    end

    // reset while holding a word, with input offered
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_valid", m_out.valid, 0);
    check("rst2_data", m_out.data, 0);
    hm = hist_of(SEED7);
    w = 8'($urandom); m_in.data = w;
    tick();
    exp = mdl(w, 1'b0, hm);
    check("rst2_fresh", m_out.data, exp);

    // seed_load coincident with accept
    for (int j = 0; j < 2; j++) begin
      w = 8'($urandom); m_in.data = w;
      tick();
      exp = mdl(w, 1'b0, hm);
      check("adv_data", m_out.data, exp);
    end
    w = 8'($urandom); m_in.data = w; seed_m = 1'b1;
    tick();
    seed_m = 1'b0;
    hm = hist_of(SEED7);
    exp = mdl(w, 1'b0, hm);
    check("seed_acc", m_out.data, exp);

    // seed_load without accept leaves the output register alone
    m_in.valid = 1'b0; m_out.ready = 1'b0; seed_m = 1'b1;
    tick();
    seed_m = 1'b0;
    check("seed_hold_valid", m_out.valid, 1);
    check("seed_hold_data", m_out.data, exp);
    hm = hist_of(SEED7);

    // random words, random mode, state carried across mode changes
    m_out.ready = 1'b1; m_in.valid = 1'b1;
    for (int j = 0; j < 24; j++) begin
      md = bit'($urandom_range(0, 1));
      w = 8'($urandom);
      mode_m = md; m_in.data = w;
      tick();
      exp = mdl(w, md, hm);
      check("rnd_data", m_out.data, exp);
`ifdef SCRAMBLER_PARITY_EN
      check("rnd_parity", m_out.parity, ^exp);
`endif
    end
    m_in.valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
